// File: rtl/shared_port_arbiter.sv
// Two-requester round-robin arbiter driving the select of a shared 2:1 port mux.
// A hold counter lets the current owner be preempted once the other requester has waited long enough.
module shared_port_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             REQ0,
  input  logic             REQ1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             SEL,
  output logic             BUSY,
  output logic             PREEMPT,
  output logic [CNT_W-1:0] HOLD_CNT
);

  // State encoding doubles as the grant vector: bit 0 = GNT0, bit 1 = GNT1.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_SAT = '1;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             sel_q, sel_d;
  logic             preempt_q, preempt_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  logic             enter;
  logic             enter_id;
  logic             cur_id;
  logic             own_req;
  logic             oth_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      sel_q     <= 1'b0;
      preempt_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      preempt_q <= preempt_d;
      hold_q    <= hold_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    sel_d     = sel_q;
    preempt_d = 1'b0;
    hold_d    = hold_q;
    enter     = 1'b0;
    enter_id  = 1'b0;
    cur_id    = (state_q == OWN1);
    own_req   = cur_id ? REQ1 : REQ0;
    oth_req   = cur_id ? REQ0 : REQ1;

    case (state_q)
      IDLE: begin
        // On a tie the requester that did not own the port last wins.
        if (REQ0 && (!REQ1 || last_q)) begin
          enter    = 1'b1;
          enter_id = 1'b0;
        end else if (REQ1) begin
          enter    = 1'b1;
          enter_id = 1'b1;
        end
      end
      OWN0, OWN1: begin
        if (!own_req) begin
          if (oth_req) begin
            enter    = 1'b1;
            enter_id = ~cur_id;
          end else begin
            state_d = IDLE;
            hold_d  = '0;
          end
        end else if (oth_req && (hold_q >= HOLD_LIM) && !preempt_q) begin
          // The !preempt_q term keeps PREEMPT a single-cycle pulse even when MAX_HOLD is 1.
          enter     = 1'b1;
          enter_id  = ~cur_id;
          preempt_d = 1'b1;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase

    if (enter) begin
      state_d = enter_id ? OWN1 : OWN0;
      sel_d   = enter_id;
      last_d  = enter_id;
      hold_d  = CNT_W'(1);
    end
  end

  assign GNT0     = state_q[0];
  assign GNT1     = state_q[1];
  assign BUSY     = |state_q;
  assign SEL      = sel_q;
  assign PREEMPT  = preempt_q;
  assign HOLD_CNT = hold_q;

endmodule

// File: tb/tb_shared_port_arbiter.sv
// Directed bench for shared_port_arbiter (MAX_HOLD=8, CNT_W=4) with a per-cycle invariant monitor.
module tb_shared_port_arbiter;

  logic       clk;
  logic       reset;
  logic       REQ0, REQ1;
  logic       GNT0, GNT1, SEL, BUSY, PREEMPT;
  logic [3:0] HOLD_CNT;

  int checks   = 0;
  int failures = 0;
  logic mon_en = 1'b0;
  logic prev_preempt = 1'b0;

  shared_port_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .REQ0     (REQ0),
    .REQ1     (REQ1),
    .GNT0     (GNT0),
    .GNT1     (GNT1),
    .SEL      (SEL),
    .BUSY     (BUSY),
    .PREEMPT  (PREEMPT),
    .HOLD_CNT (HOLD_CNT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic g0, input logic g1, input logic sel,
                            input logic busy, input logic pre, input logic [3:0] hold);
    chk({tag, ".GNT0"}, GNT0, g0);
    chk({tag, ".GNT1"}, GNT1, g1);
    chk({tag, ".SEL"}, SEL, sel);
    chk({tag, ".BUSY"}, BUSY, busy);
    chk({tag, ".PREEMPT"}, PREEMPT, pre);
    chk({tag, ".HOLD_CNT"}, HOLD_CNT, hold);
    $display("txn %-12s REQ0=%0b REQ1=%0b -> GNT0=%0b GNT1=%0b SEL=%0b BUSY=%0b PRE=%0b HOLD=%0d",
             tag, REQ0, REQ1, GNT0, GNT1, SEL, BUSY, PREEMPT, HOLD_CNT);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("inv_excl", GNT0 & GNT1, 0);
      chk("inv_busy", BUSY, GNT0 | GNT1);
      if (GNT1) chk("inv_sel1", SEL, 1);
      if (GNT0) chk("inv_sel0", SEL, 0);
      chk("inv_prepulse", prev_preempt & PREEMPT, 0);
    end
    prev_preempt = PREEMPT;
  end

  initial begin
    reset = 1'b1;
    REQ0  = 1'b1;
    REQ1  = 1'b1;

    // 1: reset with both requesting, then tie goes to requester 0
    tick();
    mon_en = 1'b1;
    tick();
    expect_out("rst", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    expect_out("tie0", 1, 0, 0, 1, 0, 1);
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    tick();
    expect_out("idle1", 0, 0, 0, 0, 0, 0);

    // 2: REQ1 alone for 3 cycles, SEL holds in IDLE afterwards
    REQ1 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      expect_out($sformatf("own1_%0d", i), 0, 1, 1, 1, 0, 4'(i));
    end
    REQ1 = 1'b0;
    tick();
    expect_out("idle_sel1", 0, 0, 1, 0, 0, 0);

    // 3: REQ0 owns, REQ1 waits, preemption every 8 cycles
    REQ0 = 1'b1;
    tick();
    expect_out("own0_1", 1, 0, 0, 1, 0, 1);
    REQ1 = 1'b1;
    for (int i = 2; i <= 8; i++) begin
      tick();
      expect_out($sformatf("own0_%0d", i), 1, 0, 0, 1, 0, 4'(i));
    end
    tick();
    expect_out("pre_to1", 0, 1, 1, 1, 1, 1);
    for (int i = 2; i <= 8; i++) begin
      tick();
      expect_out($sformatf("alt1_%0d", i), 0, 1, 1, 1, 0, 4'(i));
    end
    tick();
    expect_out("pre_to0", 1, 0, 0, 1, 1, 1);

    // 4: owner drops while other waits: direct handover, no preempt
    REQ0 = 1'b0;
    tick();
    expect_out("handover", 0, 1, 1, 1, 0, 1);
    REQ1 = 1'b0;
    tick();
    expect_out("idle4", 0, 0, 1, 0, 0, 0);

    // 5: REQ0 alone for 20 cycles, counter saturates at 15
    REQ0 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      expect_out($sformatf("sat_%0d", i), 1, 0, 0, 1, 0, (i > 15) ? 4'd15 : 4'(i));
    end
    REQ0 = 1'b0;
    tick();
    expect_out("idle5", 0, 0, 0, 0, 0, 0);

    // 6: reset in the middle of an OWN1 transaction
    REQ1 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      expect_out($sformatf("own1b_%0d", i), 0, 1, 1, 1, 0, 4'(i));
    end
    reset = 1'b1;
    REQ0  = 1'b1;
    tick();
    expect_out("rst_mid", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    expect_out("tie0_b", 1, 0, 0, 1, 0, 1);
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    tick();
    tick();
    expect_out("idle6", 0, 0, 0, 0, 0, 0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
